// File: rtl/reg_file_pkg.sv
// Shared types and constants for the MIPS general-purpose register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_file_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = $clog2(REG_COUNT);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_addr_t ZERO_ADDR = '0;
  localparam data_t     ZERO_WORD = '0;

  // True when a port is allowed to return something other than zero.
  function automatic logic rd_live(input logic rst, input logic en, input reg_addr_t addr);
    return !rst && en && (addr != ZERO_ADDR);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: enable/zero gating, optional write-through, storage mux.
// Latency: 0 cycles (purely combinational). Optional feature macro: REGFILE_BYPASS_EN.
// Backpressure: none; a read is serviced every cycle.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_NUM = REG_COUNT
) (
  input  logic                           rst_i,
  input  logic                           rd_en_i,
  input  reg_addr_t                      rd_addr_i,
  input  logic                           wr_en_i,
  input  reg_addr_t                      wr_addr_i,
  input  data_t                          wr_data_i,
  input  logic [REG_NUM-1:0][DATA_W-1:0] regs_i,
  output data_t                          rd_data_o
);

  // Gating is tested before the address is used, so an unknown address on a
  // disabled port never reaches the output.
  always_comb begin
    rd_data_o = ZERO_WORD;
    if (rd_live(rst_i, rd_en_i, rd_addr_i)) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_o = wr_data_i;
      end else begin
        rd_data_o = regs_i[rd_addr_i];
      end
`else
      rd_data_o = regs_i[rd_addr_i];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs are only consumed by the forwarding path.
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

endmodule

// File: rtl/reg_file.sv
// MIPS register file: 32 x 32-bit flops, two read ports, one write port, $zero hardwired.
// Latency: reads 0 cycles; writes visible after the edge (same cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: none; a write and two reads are accepted every cycle.
module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      read_en_1,
  input  reg_addr_t read_addr_1,
  output data_t     read_data_1,
  input  logic      read_en_2,
  input  reg_addr_t read_addr_2,
  output data_t     read_data_2,
  input  logic      write_en,
  input  reg_addr_t write_addr,
  input  data_t     write_data
);

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_q;
  logic [REG_COUNT-1:0][DATA_W-1:0] regs_d;

  // Next-state: single-entry update; $zero is never a write target.
  always_comb begin
    regs_d = regs_q;
    if (write_en && (write_addr != ZERO_ADDR)) begin
      regs_d[write_addr] = write_data;
    end
  end

  // Storage: reset clears every entry and drops any write in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_read_port #(.REG_NUM(REG_COUNT)) u_rd_port_1 (
    .rst_i     (rst),
    .rd_en_i   (read_en_1),
    .rd_addr_i (read_addr_1),
    .wr_en_i   (write_en),
    .wr_addr_i (write_addr),
    .wr_data_i (write_data),
    .regs_i    (regs_q),
    .rd_data_o (read_data_1)
  );

  reg_file_read_port #(.REG_NUM(REG_COUNT)) u_rd_port_2 (
    .rst_i     (rst),
    .rd_en_i   (read_en_2),
    .rd_addr_i (read_addr_2),
    .wr_en_i   (write_en),
    .wr_addr_i (write_addr),
    .wr_data_i (write_data),
    .regs_i    (regs_q),
    .rd_data_o (read_data_2)
  );

endmodule
